// File: rtl/seq_alu_pkg.sv
// Shared types and operation codes for the sequential shift/compare unit.
package seq_alu_pkg;

  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} seq_state_t;

  typedef struct packed {
    logic is_shift;
    logic dir_right;
    logic arith;
    logic is_signed;
    logic legal;
  } op_ctrl_t;

endpackage

// File: rtl/seq_shift_cmp_op_mode_dec.sv
// Combinational decode of the 4-bit operation code into datapath controls.
module op_mode_dec
  import seq_alu_pkg::*;
(
  input  logic [3:0] i_oper,
  output op_ctrl_t   o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_oper)
      OP_SLL: begin
        o_ctrl.is_shift = 1'b1;
        o_ctrl.legal    = 1'b1;
      end
      OP_SRL: begin
        o_ctrl.is_shift  = 1'b1;
        o_ctrl.dir_right = 1'b1;
        o_ctrl.legal     = 1'b1;
      end
      OP_SRA: begin
        o_ctrl.is_shift  = 1'b1;
        o_ctrl.dir_right = 1'b1;
        o_ctrl.arith     = 1'b1;
        o_ctrl.legal     = 1'b1;
      end
      OP_SLT: begin
        o_ctrl.is_signed = 1'b1;
        o_ctrl.legal     = 1'b1;
      end
      OP_SLTU: o_ctrl.legal = 1'b1;
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/seq_shift_cmp.sv
// Multi-cycle shift unit (STEP bits per cycle) with single-cycle compares,
// valid/ready on both sides; result is held in DONE until drained.
module seq_shift_cmp
  import seq_alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int STEP    = 1,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [3:0]       i_oper,
  input  logic [WIDTH-1:0] i_opa,
  input  logic [WIDTH-1:0] i_opb,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_illegal,
  output logic             o_busy
);

  localparam logic [SHAMT_W-1:0] STEP_V = SHAMT_W'(STEP);

  seq_state_t         state_q, state_d;
  op_ctrl_t           ctrl_q, ctrl_d, dec_ctrl;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               illegal_q, illegal_d;

  logic [SHAMT_W-1:0] shamt, amt;
  logic [WIDTH-1:0]   shifted;

  op_mode_dec u_dec (
    .i_oper (i_oper),
    .o_ctrl (dec_ctrl)
  );

  // Result selection shared by the direct (IDLE) and iterative (SHIFT) load points.
  function automatic logic [WIDTH-1:0] load_value(input op_ctrl_t c,
                                                  input logic [WIDTH-1:0] shift_val,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
    logic lt;
    if (!c.legal) return '0;
    if (c.is_shift) return shift_val;
    lt = c.is_signed ? ($signed(a) < $signed(b)) : (a < b);
    return {{(WIDTH-1){1'b0}}, lt};
  endfunction

  assign shamt = i_opb[SHAMT_W-1:0];
  assign amt   = (rem_q < STEP_V) ? rem_q : STEP_V;

  always_comb begin
    shifted = work_q;
    if (!ctrl_q.dir_right)  shifted = work_q << amt;
    else if (ctrl_q.arith)  shifted = $signed(work_q) >>> amt;
    else                    shifted = work_q >> amt;
  end

  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    work_d    = work_q;
    rem_d     = rem_q;
    result_d  = result_q;
    illegal_d = illegal_q;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          ctrl_d = dec_ctrl;
          work_d = i_opa;
          rem_d  = shamt;
          if (dec_ctrl.legal && dec_ctrl.is_shift && shamt != '0) begin
            state_d = SHIFT;
          end else begin
            result_d  = load_value(dec_ctrl, i_opa, i_opa, i_opb);
            illegal_d = !dec_ctrl.legal;
            state_d   = DONE;
          end
        end
      end
      SHIFT: begin
        work_d = shifted;
        rem_d  = rem_q - amt;
        if (rem_q == amt) begin
          result_d  = load_value(ctrl_q, shifted, work_q, work_q);
          illegal_d = !ctrl_q.legal;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
    end
  end

  // Working operands are only consumed after an accept reloads them.
  always_ff @(posedge i_clk) begin
    ctrl_q <= ctrl_d;
    work_q <= work_d;
    rem_q  <= rem_d;
  end

  assign o_ready   = (state_q == IDLE);
  assign o_valid   = (state_q == DONE);
  assign o_busy    = (state_q != IDLE);
  assign o_result  = result_q;
  assign o_illegal = illegal_q;

endmodule

// File: tb/tb_seq_shift_cmp.sv
// Scoreboard bench: two units (STEP=1 and STEP=4) driven by directed vectors.
module tb_seq_shift_cmp;
  import seq_alu_pkg::*;

  typedef struct {
    logic [31:0] res;
    logic        ill;
    int          lat;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        i_vld [2];
  logic        o_rdy [2];
  logic        o_vld [2];
  logic        i_rdy [2];
  logic        o_ill [2];
  logic        o_bsy [2];
  logic [3:0]  oper  [2];
  logic [31:0] opa   [2];
  logic [31:0] opb   [2];
  logic [31:0] res   [2];
  logic        seen  [2];

  exp_t sbq0[$];
  exp_t sbq1[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_shift_cmp #(.WIDTH(32), .STEP(1)) u_s1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_vld[0]), .o_ready(o_rdy[0]),
    .i_oper(oper[0]), .i_opa(opa[0]), .i_opb(opb[0]), .o_valid(o_vld[0]),
    .i_ready(i_rdy[0]), .o_result(res[0]), .o_illegal(o_ill[0]), .o_busy(o_bsy[0])
  );

  seq_shift_cmp #(.WIDTH(32), .STEP(4)) u_s4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_vld[1]), .o_ready(o_rdy[1]),
    .i_oper(oper[1]), .i_opa(opa[1]), .i_opb(opb[1]), .o_valid(o_vld[1]),
    .i_ready(i_rdy[1]), .o_result(res[1]), .o_illegal(o_ill[1]), .o_busy(o_bsy[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic issue(input int d, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] er, input logic ei,
                       input int el, input bit track);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (o_rdy[d] !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (o_rdy[d] !== 1'b1) begin
      chk("ready_timeout", {31'b0, o_rdy[d]}, 32'd1);
      return;
    end
    e.res = er; e.ill = ei; e.lat = el; e.acc = cyc + 1;
    if (track) begin
      if (d == 0) sbq0.push_back(e);
      else        sbq1.push_back(e);
    end
    i_vld[d] = 1'b1; oper[d] = op; opa[d] = a; opb[d] = b;
    @(posedge clk);
    #1 i_vld[d] = 1'b0;
  endtask

  // Monitor: pops one expectation on each rising edge of o_valid.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (o_vld[d] === 1'b1 && !seen[d]) begin
        seen[d] = 1'b1;
        if ((d == 0 && sbq0.size() == 0) || (d == 1 && sbq1.size() == 0)) begin
          chk("unexpected_valid", 32'd1, 32'd0);
        end else begin
          if (d == 0) e = sbq0.pop_front();
          else        e = sbq1.pop_front();
          chk($sformatf("result_u%0d", d), res[d], e.res);
          chk($sformatf("illegal_u%0d", d), {31'b0, o_ill[d]}, {31'b0, e.ill});
          chk($sformatf("latency_u%0d", d), cyc - e.acc + 1, e.lat);
        end
      end else if (o_vld[d] !== 1'b1) begin
        seen[d] = 1'b0;
      end
    end
  end

  initial begin
    int n;
    for (int d = 0; d < 2; d++) begin
      i_vld[d] = 0; i_rdy[d] = 1; oper[d] = 0; opa[d] = 0; opb[d] = 0; seen[d] = 0;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", {31'b0, o_vld[0]}, 32'd0);
    chk("rst_result", res[0], 32'd0);
    chk("rst_illegal", {31'b0, o_ill[0]}, 32'd0);
    chk("rst_busy", {31'b0, o_bsy[0]}, 32'd0);
    chk("rst_ready", {31'b0, o_rdy[0]}, 32'd1);
    chk("rst_ready_u1", {31'b0, o_rdy[1]}, 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // SRA of negative value, busy held through the shift
    issue(0, OP_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 5, 1);
    n = 0;
    @(negedge clk);
    while (o_vld[0] !== 1'b1 && n < 50) begin
      chk("busy_shift", {31'b0, o_bsy[0]}, 32'd1);
      @(negedge clk);
      n++;
    end
    chk("busy_done", {31'b0, o_bsy[0]}, 32'd1);

    issue(0, OP_SLL, 32'h1234_5678, 32'h20, 32'h1234_5678, 1'b0, 1, 1);
    issue(0, OP_SLL, 32'h1234_5678, 32'h21, 32'h2468_ACF0, 1'b0, 2, 1);
    issue(0, OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1, 1);
    issue(0, OP_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1, 1);
    issue(0, OP_SLL, 32'h0000_0001, 32'hFFFF_FFE1, 32'h0000_0002, 1'b0, 2, 1);
    issue(0, OP_SRL, 32'h8000_0000, 32'h3F, 32'h0000_0001, 1'b0, 32, 1);

    issue(1, OP_SRL, 32'hFFFF_FFFF, 32'd31, 32'h0000_0001, 1'b0, 9, 1);
    issue(1, OP_SRA, 32'hFFFF_FFFF, 32'd31, 32'hFFFF_FFFF, 1'b0, 9, 1);
    issue(1, OP_SRA, 32'h7FFF_FFFF, 32'd31, 32'h0000_0000, 1'b0, 9, 1);
    issue(1, OP_SLL, 32'h0000_0001, 32'd5, 32'h0000_0020, 1'b0, 3, 1);

    // Back-pressure: result held in DONE, new requests ignored
    n = 0;
    @(negedge clk);
    while (o_rdy[0] !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    i_rdy[0] = 1'b0;
    issue(0, OP_SLTU, 32'd1, 32'd2, 32'd1, 1'b0, 1, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold_valid", {31'b0, o_vld[0]}, 32'd1);
      chk("hold_result", res[0], 32'd1);
      chk("hold_illegal", {31'b0, o_ill[0]}, 32'd0);
      chk("hold_ready", {31'b0, o_rdy[0]}, 32'd0);
      i_vld[0] = 1'b1; oper[0] = OP_SLL; opa[0] = 32'hFF; opb[0] = 32'd3;
    end
    @(negedge clk);
    i_vld[0] = 1'b0;
    i_rdy[0] = 1'b1;
    @(negedge clk);
    chk("drain_ready", {31'b0, o_rdy[0]}, 32'd1);
    chk("drain_valid", {31'b0, o_vld[0]}, 32'd0);
    chk("drain_busy", {31'b0, o_bsy[0]}, 32'd0);

    // Asynchronous reset in the middle of a long shift
    issue(0, OP_SRL, 32'hFFFF_FFFF, 32'd20, 32'd0, 1'b0, 0, 0);
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_valid", {31'b0, o_vld[0]}, 32'd0);
    chk("abort_result", res[0], 32'd0);
    chk("abort_busy", {31'b0, o_bsy[0]}, 32'd0);
    chk("abort_ready", {31'b0, o_rdy[0]}, 32'd1);
    chk("abort_result_u1", res[1], 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(0, 4'b1111, 32'h1234_5678, 32'd9, 32'd0, 1'b1, 1, 1);

    n = 0;
    while ((sbq0.size() != 0 || sbq1.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("pending_u0", sbq0.size(), 32'd0);
    chk("pending_u1", sbq1.size(), 32'd0);
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
